fan_sum_collector: RTL and testbench
====================================

// Module: fan_sum_collector
// PURPOSE
//   Downstream stage of the FAN reduction tree. Captures one batch of N-1 tree partial sums with their
//   valid mask and vector IDs. Streams only the valid entries out, one per cycle, in ascending node
//   index order over a valid/ready handshake. Backpressures the tree side while a batch is draining.
// PARAMETERS
//   N  4            operand count of the feeding tree; power of two, >= 4
//   W  8            operand bit-width
//   V  3            vector-ID bit-width
//   S  W+$clog2(N)  sum bit-width (matches tree output)
//   IW $clog2(N-1)  node-index width (derived localparam, not overridable)
// PORTS
//   clk           in   1           clock, all state on rising edge
//   rst           in   1           asynchronous active-high reset
//   in_valid      in   1           batch present on in_* this cycle
//   in_ready      out  1           collector accepts batch this cycle
//   in_sums       in   (N-1)*S     packed [N-2:0][S-1:0] partial sums
//   in_sum_valids in   N-1         per-node valid mask
//   in_sum_ids    in   (N-1)*V     packed [N-2:0][V-1:0] vector ID per node
//   out_valid     out  1           result present on out_*
//   out_ready     in   1           consumer accepts result
//   out_sum       out  S           selected sum
//   out_id        out  V           vector ID of out_sum
//   out_idx       out  IW          tree node index of out_sum
//   out_last      out  1           current result is the final one of its batch
//   perf_count    out  32          emitted-result counter (only with FAN_COLLECT_CNT_EN)
// BEHAVIOUR
//   - Reset (async, any time incl. mid-drain):
//     - state IDLE, pending mask 0, buffers 0.
//     - out_valid=0, out_sum=0, out_id=0, out_idx=0, out_last=0, perf_count=0.
//     - in_ready=1 on the first edge after deassertion.
//   - States IDLE / DRAIN.
//     - IDLE: in_ready=1, out_valid=0.
//     - DRAIN: out_valid=1.
//   - Accept = in_valid && in_ready.
//     - On accept, register in_sums, in_sum_ids and mask=in_sum_valids.
//     - Go to DRAIN if the mask is nonzero. Stay or return to IDLE if the mask is zero (empty batch).
//     - An empty batch is consumed and emits nothing.
//   - Latency: the first result is visible the cycle after accept.
//   - Selection: lowest set bit k of the pending mask.
//     - out_sum = sums[k], out_id = ids[k], out_idx = k.
//     - out_last = (mask has exactly one bit set).
//     - All out_* are driven from registered state, with no combinational path from in_*.
//   - Output handshake (out_valid && out_ready): clear bit k.
//     - If out_last, leave DRAIN.
//   - out_* hold stable while out_valid && !out_ready (AXI-style; no retraction).
//   - in_ready = (state==IDLE) || (out_valid && out_ready && out_last).
//     - This permits back-to-back batches with zero bubble.
//     - A batch accepted on the last handshake replaces the buffer on the same edge.
//   - in_valid with in_ready=0: the collector ignores it, and the upstream holds the batch.
//   - Sums pass through unmodified at width S. No arithmetic is performed.
//   - in_sum_valids bits for nodes never produced by the tree are honoured as given.
//     The collector does not filter them.
// CONFIGURATION
//   FAN_COLLECT_CNT_EN defined:
//     - perf_count is present.
//     - It increments by 1 on every output handshake and wraps 2^32-1 -> 0.
//     - It is reset only by rst.
//   Undefined:
//     - The perf_count port and counter do not exist. All other behaviour is identical.
// TESTING (N=4, W=8, V=3, S=10)
//   1. Reset: assert rst mid-DRAIN with out_ready=0.
//      -> out_valid=0 immediately; in_ready=1 after release; stale entries never emitted.
//   2. Mask 3'b101, sums {30,0,10}, ids {2,0,1}, out_ready=1.
//      -> cycle+1: sum=10 id=1 idx=0 last=0; cycle+2: sum=30 id=2 idx=2 last=1.
//   3. Same batch, out_ready=0 for 3 cycles.
//      -> out_* hold sum=10 idx=0; in_ready=0 throughout; then drains as in test 2.
//   4. Empty batch (mask 0) followed by mask 3'b010 sum 55.
//      -> nothing emitted for the first; sum=55 idx=1 last=1 one cycle after the second accept.
//   5. Back-to-back: batch A mask 3'b001, batch B held on in_valid, out_ready=1.
//      -> B accepted on A's last handshake; B's first result on the next cycle; no gap.
//   6. FAN_COLLECT_CNT_EN build: emit 5 results across 3 batches.
//      -> perf_count=5. Preload via force to 32'hFFFFFFFF, then one handshake -> 0.

Source files
------------

// File: rtl/fan_sum_collector.sv
// FAN reduction-tree collector: buffers one batch of N-1 partial sums and streams the valid ones out
// lowest node index first. Define FAN_COLLECT_CNT_EN to add the perf_count emitted-result counter.
module fan_sum_collector #(
  parameter int N = 4,
  parameter int W = 8,
  parameter int V = 3,
  parameter int S = W + $clog2(N)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [N-2:0][S-1:0]     in_sums,
  input  logic [N-2:0]            in_sum_valids,
  input  logic [N-2:0][V-1:0]     in_sum_ids,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [S-1:0]            out_sum,
  output logic [V-1:0]            out_id,
  output logic [$clog2(N-1)-1:0]  out_idx,
  output logic                    out_last
`ifdef FAN_COLLECT_CNT_EN
  , output logic [31:0]           perf_count
`endif
);

  localparam int IW = $clog2(N-1);
  localparam int M  = N - 1;

  typedef enum logic [0:0] {IDLE = 1'b0, DRAIN = 1'b1} state_t;

  function automatic logic [IW-1:0] lowest_idx(input logic [M-1:0] m);
    lowest_idx = {IW{1'b0}};
    for (int i = M - 1; i >= 0; i--) begin
      if (m[i]) lowest_idx = IW'(i);
    end
  endfunction

  state_t              state_q, state_d;
  logic [M-1:0]        mask_q, mask_d;
  logic [M-1:0][S-1:0] sums_q, sums_d;
  logic [M-1:0][V-1:0] ids_q, ids_d;
  logic                out_valid_q, out_valid_d;
  logic [S-1:0]        out_sum_q, out_sum_d;
  logic [V-1:0]        out_id_q, out_id_d;
  logic [IW-1:0]       out_idx_q, out_idx_d;
  logic                out_last_q, out_last_d;
  logic [IW-1:0]       sel;
  logic                accept;
  logic                handshake;

  assign handshake = out_valid_q && out_ready;
  assign in_ready  = (state_q == IDLE) || (handshake && out_last_q);
  assign accept    = in_valid && in_ready;

  // Outputs are registered from the post-edge mask, so the first result shows the cycle after accept.
  always_comb begin
    state_d     = state_q;
    sums_d      = sums_q;
    ids_d       = ids_q;
    mask_d      = mask_q;
    out_valid_d = 1'b0;
    out_sum_d   = {S{1'b0}};
    out_id_d    = {V{1'b0}};
    out_idx_d   = {IW{1'b0}};
    out_last_d  = 1'b0;
    if (accept) begin
      mask_d = in_sum_valids;
      sums_d = in_sums;
      ids_d  = in_sum_ids;
    end else if (handshake) begin
      mask_d = mask_q & ~(M'(1'b1) << out_idx_q);
    end else begin
      mask_d = mask_q;
    end
    sel = lowest_idx(mask_d);
    if (mask_d != {M{1'b0}}) begin
      state_d     = DRAIN;
      out_valid_d = 1'b1;
      out_sum_d   = sums_d[sel];
      out_id_d    = ids_d[sel];
      out_idx_d   = sel;
      out_last_d  = ((mask_d & (mask_d - M'(1'b1))) == {M{1'b0}});
    end else begin
      state_d = IDLE;
    end
  end

  // State, batch buffer and registered output stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      mask_q      <= {M{1'b0}};
      sums_q      <= '0;
      ids_q       <= '0;
      out_valid_q <= 1'b0;
      out_sum_q   <= {S{1'b0}};
      out_id_q    <= {V{1'b0}};
      out_idx_q   <= {IW{1'b0}};
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      mask_q      <= mask_d;
      sums_q      <= sums_d;
      ids_q       <= ids_d;
      out_valid_q <= out_valid_d;
      out_sum_q   <= out_sum_d;
      out_id_q    <= out_id_d;
      out_idx_q   <= out_idx_d;
      out_last_q  <= out_last_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;
  assign out_id    = out_id_q;
  assign out_idx   = out_idx_q;
  assign out_last  = out_last_q;

`ifdef FAN_COLLECT_CNT_EN
  logic [31:0] perf_q;

  // Emitted-result counter; wraps naturally at 2^32.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_q <= 32'd0;
    end else if (handshake) begin
      perf_q <= perf_q + 32'd1;
    end else begin
      perf_q <= perf_q;
    end
  end

  assign perf_count = perf_q;
`endif

endmodule

// File: tb/tb_fan_sum_collector.sv
// Directed testbench for fan_sum_collector (N=4, W=8, V=3, S=10); perf_count checks need FAN_COLLECT_CNT_EN.
module tb_fan_sum_collector;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [2:0][9:0] in_sums;
  logic [2:0]      in_sum_valids;
  logic [2:0][2:0] in_sum_ids;
  logic            out_valid;
  logic            out_ready;
  logic [9:0]      out_sum;
  logic [2:0]      out_id;
  logic [1:0]      out_idx;
  logic            out_last;
`ifdef FAN_COLLECT_CNT_EN
  logic [31:0]     perf_count;
`endif

  int errors = 0;
  int checks = 0;

  fan_sum_collector #(.N(4), .W(8), .V(3)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_sums(in_sums), .in_sum_valids(in_sum_valids), .in_sum_ids(in_sum_ids),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_id(out_id), .out_idx(out_idx), .out_last(out_last)
`ifdef FAN_COLLECT_CNT_EN
    , .perf_count(perf_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic v, input int sum, input int id,
                            input int idx, input logic last);
    check({tag, ".valid"}, 32'(out_valid), 32'(v));
    if (v) begin
      check({tag, ".sum"},  32'(out_sum),  32'(sum));
      check({tag, ".id"},   32'(out_id),   32'(id));
      check({tag, ".idx"},  32'(out_idx),  32'(idx));
      check({tag, ".last"}, 32'(out_last), 32'(last));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [2:0] mask, input int s2, input int s1, input int s0,
                      input int i2, input int i1, input int i0);
    in_valid      = 1'b1;
    in_sum_valids = mask;
    in_sums       = {10'(s2), 10'(s1), 10'(s0)};
    in_sum_ids    = {3'(i2), 3'(i1), 3'(i0)};
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_sums = '0; in_sum_valids = 3'b000; in_sum_ids = '0;
    tick(); tick();
    rst = 1'b0;
    tick();
    check("rst.in_ready", 32'(in_ready), 32'd1);
    expect_out("rst", 1'b0, 0, 0, 0, 1'b0);

    // 1: reset during a stalled drain
    load(3'b111, 3, 2, 1, 3, 2, 1);
    tick();
    in_valid = 1'b0;
    expect_out("t1.pre", 1'b1, 1, 1, 0, 1'b0);
    rst = 1'b1;
    #1;
    check("t1.async_valid", 32'(out_valid), 32'd0);
    check("t1.async_sum", 32'(out_sum), 32'd0);
    tick();
    rst = 1'b0;
    tick();
    check("t1.in_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t1.stale", 32'(out_valid), 32'd0);
    end

    // 2: mask 101 streams idx0 then idx2
    load(3'b101, 30, 0, 10, 2, 0, 1);
    check("t2.in_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    expect_out("t2.c1", 1'b1, 10, 1, 0, 1'b0);
    check("t2.c1_in_ready", 32'(in_ready), 32'd0);
    tick();
    expect_out("t2.c2", 1'b1, 30, 2, 2, 1'b1);
    check("t2.c2_in_ready", 32'(in_ready), 32'd1);
    tick();
    expect_out("t2.end", 1'b0, 0, 0, 0, 1'b0);

    // 3: same batch, three stall cycles
    out_ready = 1'b0;
    load(3'b101, 30, 0, 10, 2, 0, 1);
    tick();
    load(3'b111, 7, 7, 7, 7, 7, 7);
    for (int i = 0; i < 3; i++) begin
      expect_out("t3.hold", 1'b1, 10, 1, 0, 1'b0);
      check("t3.in_ready", 32'(in_ready), 32'd0);
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    expect_out("t3.d1", 1'b1, 10, 1, 0, 1'b0);
    tick();
    expect_out("t3.d2", 1'b1, 30, 2, 2, 1'b1);
    tick();
    expect_out("t3.end", 1'b0, 0, 0, 0, 1'b0);

    // 4: empty batch then single-entry batch
    load(3'b000, 77, 77, 77, 1, 1, 1);
    tick();
    expect_out("t4.empty", 1'b0, 0, 0, 0, 1'b0);
    check("t4.in_ready", 32'(in_ready), 32'd1);
    load(3'b010, 0, 55, 0, 0, 5, 0);
    tick();
    in_valid = 1'b0;
    expect_out("t4.one", 1'b1, 55, 5, 1, 1'b1);
    tick();
    expect_out("t4.end", 1'b0, 0, 0, 0, 1'b0);
`ifdef FAN_COLLECT_CNT_EN
    check("t6.count5", perf_count, 32'd5);
`endif

    // 5: back-to-back batches, B taken on A's last handshake
    load(3'b001, 0, 0, 7, 0, 0, 3);
    tick();
    load(3'b110, 20, 40, 0, 6, 4, 0);
    expect_out("t5.a", 1'b1, 7, 3, 0, 1'b1);
    check("t5.in_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    expect_out("t5.b1", 1'b1, 40, 4, 1, 1'b0);
    tick();
    expect_out("t5.b2", 1'b1, 20, 6, 2, 1'b1);
    tick();
    expect_out("t5.end", 1'b0, 0, 0, 0, 1'b0);

`ifdef FAN_COLLECT_CNT_EN
    // 6: counter wrap
    out_ready = 1'b0;
    load(3'b001, 0, 0, 9, 0, 0, 1);
    tick();
    in_valid = 1'b0;
    force dut.perf_q = 32'hFFFF_FFFF;
    #1;
    release dut.perf_q;
    check("t6.preload", perf_count, 32'hFFFF_FFFF);
    out_ready = 1'b1;
    tick();
    check("t6.wrap", perf_count, 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
